// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared constants for the record-aware FIFO round-robin arbiter.
// State encoding and LAST-flag position helper.
package fifo_rr_arbiter_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  function automatic int last_pos(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set req bit at or after base,
// wrapping modulo NUM_IN.
module rr_pick #(
  parameter int NUM_IN   = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [NUM_IN-1:0]   req,
  input  logic [IDX_BITS-1:0] base,
  output logic                found,
  output logic [IDX_BITS-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = (int'(base) + k) % NUM_IN;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDX_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains NUM_IN fallthrough FIFOs into one registered stream,
// holding a grant until the word carrying LAST is popped.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int IDX_BITS = 2,
  parameter int WIDTH    = 72
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_empty,
  output logic [NUM_IN-1:0]       in_rd_en,
  input  logic [NUM_IN-1:0]       cfg_mask,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDX_BITS-1:0]     out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int LAST = last_pos(WIDTH);

  logic                state;
  logic                state_nx;
  logic [IDX_BITS-1:0] last_grant;
  logic [IDX_BITS-1:0] lock_idx;
  logic [IDX_BITS-1:0] base;
  logic [IDX_BITS-1:0] pick_idx;
  logic [IDX_BITS-1:0] g;
  logic                pick_found;
  logic                load_ok;
  logic                pop;
  logic                word_last;
  logic [NUM_IN-1:0]   req;
  logic [WIDTH-1:0]    word;

  assign req = ~in_empty & ~cfg_mask;

  assign base = (last_grant == IDX_BITS'(NUM_IN-1))
              ? '0
              : last_grant + 1'b1;

  rr_pick #(
    .NUM_IN   (NUM_IN),
    .IDX_BITS (IDX_BITS)
  ) u_pick (
    .req   (req),
    .base  (base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign load_ok   = !out_valid || out_ready;
  assign word      = in_data[int'(g)*WIDTH +: WIDTH];
  assign word_last = word[LAST];
  assign busy      = (state == ST_LOCKED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (pop && !word_last) state_nx = ST_LOCKED;
      ST_LOCKED:
        if (pop && word_last) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Locked sources ignore cfg_mask so records always complete.
  always_comb begin
    g   = lock_idx;
    pop = 1'b0;
    unique case (state)
      ST_IDLE: begin
        g   = pick_idx;
        pop = pick_found && load_ok;
      end
      ST_LOCKED:
        pop = !in_empty[lock_idx] && load_ok;
      default: pop = 1'b0;
    endcase
    in_rd_en = '0;
    if (pop && reset_n) in_rd_en[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDX_BITS'(NUM_IN-1);
      lock_idx   <= '0;
    end else if (pop) begin
      if (word_last) last_grant <= g;
      else           lock_idx   <= g;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_data  <= word;
      out_src   <= g;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
